stack_sequencer: RTL and testbench

Multi-cycle initiator for the data-memory stack port. It turns single-cycle CALL/RET/INT/RTI requests from the execute stage into ordered `memory_push`/`memory_pop` word sequences toward the memory stage, and reassembles popped words into a 32-bit PC and flags. It holds the front end with `busy` until it issues the PC redirect. It also tracks stack occupancy and refuses sequences that would overflow or underflow the stack.

---
 rtl/stack_sequencer_if.sv | 41 ++++
 rtl/stack_sequencer.sv | 277 +++++++++++++++++++++++++++
 tb/tb_stack_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_sequencer_if.sv
// Bundle between the execute stage, the stack sequencer and the memory stage.
// Handshake: a request transfers on a rising edge where op_valid=1 and op_ready=1.
// op_valid is ignored while op_ready=0. There is no queueing, and the requester
// needs no acknowledge beyond op_ready/busy. memory_push/memory_pop are
// single-cycle strobes that the memory stage always accepts. data_r is valid the
// cycle after a pop.
interface stack_sequencer_if #(
    parameter int FLAG_W = 3
);
    logic              op_valid;
    logic [1:0]        op_code;
    logic [31:0]       pc_in;
    logic [31:0]       target_in;
    logic [FLAG_W-1:0] flags_in;
    logic              op_ready;
    logic              busy;
    logic              memory_push;
    logic              memory_pop;
    logic [15:0]       write_data;
    logic [15:0]       data_r;
    logic              pc_load;
    logic [31:0]       pc_out;
    logic              flags_load;
    logic [FLAG_W-1:0] flags_out;
    logic              stack_fault;
    logic [11:0]       depth;

    // Sequencer side
    modport slave (
        input  op_valid, op_code, pc_in, target_in, flags_in, data_r,
        output op_ready, busy, memory_push, memory_pop, write_data,
               pc_load, pc_out, flags_load, flags_out, stack_fault, depth
    );

    // Environment side (execute stage + memory stage)
    modport master (
        output op_valid, op_code, pc_in, target_in, flags_in, data_r,
        input  op_ready, busy, memory_push, memory_pop, write_data,
               pc_load, pc_out, flags_load, flags_out, stack_fault, depth
    );
endinterface

// File: rtl/stack_sequencer.sv
// Stack sequencer: expands CALL/RET/INT/RTI into 16-bit push/pop sequences,
// reassembles popped words into PC and flags, and tracks stack occupancy.
// All bus outputs are registered. They are decoded from the next state so
// that each one appears in the same cycle as the state that owns it.
module stack_sequencer #(
    parameter int          STACK_DEPTH = 2048,
    parameter int          FLAG_W      = 3,
    parameter logic [31:0] INT_VECTOR  = 32'h0000_0020
) (
    input  logic               clk,
    input  logic               reset,      // asynchronous, active-low
    stack_sequencer_if.slave   bus,
    output logic [3:0]         o_state     // debug view of the FSM state
);

    localparam logic [1:0] OP_CALL = 2'b00;
    localparam logic [1:0] OP_RET  = 2'b01;
    localparam logic [1:0] OP_INT  = 2'b10;
    localparam logic [1:0] OP_RTI  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_PUSH_FLAGS = 4'd1,
        S_PUSH_HI    = 4'd2,
        S_PUSH_LO    = 4'd3,
        S_POP_LO     = 4'd4,
        S_POP_HI     = 4'd5,
        S_POP_FLAGS  = 4'd6,
        S_DRAIN      = 4'd7,
        S_COMMIT     = 4'd8,
        S_FAULT      = 4'd9
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    // Latched operands
    logic [1:0]         r_op;
    logic [31:0]        r_pc;
    logic [31:0]        r_target;
    logic [FLAG_W-1:0]  r_flags_in;

    // Pop reassembly
    logic               r_pop_d;
    logic [1:0]         r_cap_idx;
    logic [15:0]        r_lo;
    logic [15:0]        r_hi;
    logic [FLAG_W-1:0]  r_flags_rd;

    logic [11:0]        r_depth;

    // Registered outputs
    logic               r_op_ready;
    logic               r_push;
    logic               r_pop;
    logic [15:0]        r_wdata;
    logic               r_pc_load;
    logic [31:0]        r_pc_out;
    logic               r_flags_load;
    logic [FLAG_W-1:0]  r_flags_out;
    logic               r_fault;

    // Next-cycle output values
    logic               w_op_ready;
    logic               w_push;
    logic               w_pop;
    logic [15:0]        w_wdata;
    logic               w_pc_load;
    logic [31:0]        w_pc_out;
    logic               w_flags_load;
    logic [FLAG_W-1:0]  w_flags_out;
    logic               w_fault;

    logic               w_accept;
    logic               w_room_ok;
    int                 w_depth_i;
    logic [1:0]         w_op;
    logic [31:0]        w_pc;
    logic [31:0]        w_target;
    logic [FLAG_W-1:0]  w_flags_in;
    logic               w_cap_lo;
    logic               w_cap_hi;
    logic               w_cap_fl;
    logic [15:0]        w_lo;
    logic [15:0]        w_hi;
    logic [FLAG_W-1:0]  w_flags_rd;

    // On the accept edge the operand registers are not loaded yet, so the
    // output decode looks straight at the request inputs in that cycle.
    assign w_accept   = (r_state == S_IDLE) && bus.op_valid;
    assign w_op       = w_accept ? bus.op_code   : r_op;
    assign w_pc       = w_accept ? bus.pc_in     : r_pc;
    assign w_target   = w_accept ? bus.target_in : r_target;
    assign w_flags_in = w_accept ? bus.flags_in  : r_flags_in;

    // A popped word is on data_r in the cycle after its pop. The last word
    // is forwarded so that COMMIT can present it on the same edge it is captured.
    assign w_cap_lo   = r_pop_d && (r_cap_idx == 2'd0);
    assign w_cap_hi   = r_pop_d && (r_cap_idx == 2'd1);
    assign w_cap_fl   = r_pop_d && (r_cap_idx == 2'd2);
    assign w_lo       = w_cap_lo ? bus.data_r : r_lo;
    assign w_hi       = w_cap_hi ? bus.data_r : r_hi;
    assign w_flags_rd = w_cap_fl ? bus.data_r[FLAG_W-1:0] : r_flags_rd;

    assign w_depth_i  = int'(r_depth);

    // Occupancy check for the request being offered in IDLE
    always_comb begin
        w_room_ok = 1'b0;
        case (bus.op_code)
            OP_CALL: w_room_ok = (w_depth_i <= STACK_DEPTH - 2);
            OP_INT:  w_room_ok = (w_depth_i <= STACK_DEPTH - 3);
            OP_RET:  w_room_ok = (w_depth_i >= 2);
            default: w_room_ok = (w_depth_i >= 3);
        endcase
    end

    // State and output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_op_ready   <= 1'b1;
            r_push       <= 1'b0;
            r_pop        <= 1'b0;
            r_wdata      <= '0;
            r_pc_load    <= 1'b0;
            r_pc_out     <= '0;
            r_flags_load <= 1'b0;
            r_flags_out  <= '0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_op_ready   <= w_op_ready;
            r_push       <= w_push;
            r_pop        <= w_pop;
            r_wdata      <= w_wdata;
            r_pc_load    <= w_pc_load;
            r_pc_out     <= w_pc_out;
            r_flags_load <= w_flags_load;
            r_flags_out  <= w_flags_out;
            r_fault      <= w_fault;
        end
    end

    // Next-state sequencing for each operation
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.op_valid) begin
                    if (!w_room_ok)                 w_next_state = S_FAULT;
                    else if (bus.op_code == OP_CALL) w_next_state = S_PUSH_HI;
                    else if (bus.op_code == OP_INT)  w_next_state = S_PUSH_FLAGS;
                    else                             w_next_state = S_POP_LO;
                end
            end
            S_PUSH_FLAGS: w_next_state = S_PUSH_HI;
            S_PUSH_HI:    w_next_state = S_PUSH_LO;
            S_PUSH_LO:    w_next_state = S_COMMIT;
            S_POP_LO:     w_next_state = S_POP_HI;
            S_POP_HI:     w_next_state = (r_op == OP_RTI) ? S_POP_FLAGS : S_DRAIN;
            S_POP_FLAGS:  w_next_state = S_DRAIN;
            S_DRAIN:      w_next_state = S_COMMIT;
            S_COMMIT:     w_next_state = S_IDLE;
            S_FAULT:      w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
        endcase
    end

    // Output decode of the state being entered
    always_comb begin
        w_op_ready   = (w_next_state == S_IDLE);
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_wdata      = '0;
        w_pc_load    = 1'b0;
        w_pc_out     = '0;
        w_flags_load = 1'b0;
        w_flags_out  = '0;
        w_fault      = 1'b0;
        case (w_next_state)
            S_PUSH_FLAGS: begin
                w_push  = 1'b1;
                w_wdata = 16'(w_flags_in);
            end
            S_PUSH_HI: begin
                w_push  = 1'b1;
                w_wdata = w_pc[31:16];
            end
            S_PUSH_LO: begin
                w_push  = 1'b1;
                w_wdata = w_pc[15:0];
            end
            S_POP_LO, S_POP_HI, S_POP_FLAGS: begin
                w_pop = 1'b1;
            end
            S_COMMIT: begin
                w_pc_load = 1'b1;
                case (w_op)
                    OP_CALL: w_pc_out = w_target;
                    OP_INT:  w_pc_out = INT_VECTOR;
                    default: w_pc_out = {w_hi, w_lo};
                endcase
                if (w_op == OP_RTI) begin
                    w_flags_load = 1'b1;
                    w_flags_out  = w_flags_rd;
                end
            end
            S_FAULT: begin
                w_fault = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Operand latch on accept; later operand changes are ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op       <= OP_CALL;
            r_pc       <= '0;
            r_target   <= '0;
            r_flags_in <= '0;
        end else if (w_accept) begin
            r_op       <= bus.op_code;
            r_pc       <= bus.pc_in;
            r_target   <= bus.target_in;
            r_flags_in <= bus.flags_in;
        end
    end

    // Capture popped words in LO, HI, FLAGS order
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pop_d    <= 1'b0;
            r_cap_idx  <= 2'd0;
            r_lo       <= '0;
            r_hi       <= '0;
            r_flags_rd <= '0;
        end else begin
            r_pop_d <= r_pop;
            if (r_state == S_IDLE) begin
                r_cap_idx <= 2'd0;
            end else if (r_pop_d) begin
                r_cap_idx  <= r_cap_idx + 2'd1;
                r_lo       <= w_lo;
                r_hi       <= w_hi;
                r_flags_rd <= w_flags_rd;
            end
        end
    end

    // Occupancy counter, saturating at both ends
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_depth <= '0;
        end else if (r_push && (r_depth != 12'hFFF)) begin
            r_depth <= r_depth + 12'd1;
        end else if (r_pop && (r_depth != 12'd0)) begin
            r_depth <= r_depth - 12'd1;
        end
    end

    assign bus.op_ready    = r_op_ready;
    assign bus.busy        = ~r_op_ready;
    assign bus.memory_push = r_push;
    assign bus.memory_pop  = r_pop;
    assign bus.write_data  = r_wdata;
    assign bus.pc_load     = r_pc_load;
    assign bus.pc_out      = r_pc_out;
    assign bus.flags_load  = r_flags_load;
    assign bus.flags_out   = r_flags_out;
    assign bus.stack_fault = r_fault;
    assign bus.depth       = r_depth;
    assign o_state         = r_state;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: a full-size instance with a LIFO memory
// model, and a STACK_DEPTH=4 instance for the occupancy limits.
module tb_stack_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;          // 0: full-size DUT, 1: depth-4 DUT
    logic        op_valid = 1'b0;
    logic [1:0]  op_code = 2'b00;
    logic [31:0] pc_in = '0;
    logic [31:0] target_in = '0;
    logic [2:0]  flags_in = '0;

    int total = 0;
    int bad = 0;

    stack_sequencer_if #(.FLAG_W(3)) if0 ();
    stack_sequencer_if #(.FLAG_W(3)) if4 ();
    logic [3:0] state0;
    logic [3:0] state4;

    stack_sequencer #(.STACK_DEPTH(2048), .FLAG_W(3), .INT_VECTOR(32'h0000_0020)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave), .o_state(state0)
    );
    stack_sequencer #(.STACK_DEPTH(4), .FLAG_W(3), .INT_VECTOR(32'h0000_0020)) dut4 (
        .clk(clk), .reset(reset), .bus(if4.slave), .o_state(state4)
    );

    // Clock and shared request drive
    always #5 clk = ~clk;

    assign if0.op_valid  = op_valid & ~sel;
    assign if0.op_code   = op_code;
    assign if0.pc_in     = pc_in;
    assign if0.target_in = target_in;
    assign if0.flags_in  = flags_in;
    assign if4.op_valid  = op_valid & sel;
    assign if4.op_code   = op_code;
    assign if4.pc_in     = pc_in;
    assign if4.target_in = target_in;
    assign if4.flags_in  = flags_in;
    assign if4.data_r    = 16'h0000;

    // LIFO memory model for the full-size DUT; pop data is registered
    logic [15:0] mem0 [0:15];
    logic [3:0]  sp0;
    logic [15:0] data_r0;
    assign if0.data_r = data_r0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp0     <= 4'd0;
            data_r0 <= 16'h0000;
        end else if (if0.memory_push) begin
            mem0[sp0] <= if0.write_data;
            sp0       <= sp0 + 4'd1;
        end else if (if0.memory_pop) begin
            data_r0 <= mem0[sp0 - 4'd1];
            sp0     <= sp0 - 4'd1;
        end
    end

    // Observed outputs of the selected DUT
    logic        obs_ready, obs_busy, obs_push, obs_pop, obs_pc_load, obs_flags_load, obs_fault;
    logic [15:0] obs_wdata;
    logic [31:0] obs_pc_out;
    logic [2:0]  obs_flags_out;
    logic [11:0] obs_depth;
    logic [3:0]  obs_state;
    assign obs_ready      = sel ? if4.op_ready    : if0.op_ready;
    assign obs_busy       = sel ? if4.busy        : if0.busy;
    assign obs_push       = sel ? if4.memory_push : if0.memory_push;
    assign obs_pop        = sel ? if4.memory_pop  : if0.memory_pop;
    assign obs_wdata      = sel ? if4.write_data  : if0.write_data;
    assign obs_pc_load    = sel ? if4.pc_load     : if0.pc_load;
    assign obs_pc_out     = sel ? if4.pc_out      : if0.pc_out;
    assign obs_flags_load = sel ? if4.flags_load  : if0.flags_load;
    assign obs_flags_out  = sel ? if4.flags_out   : if0.flags_out;
    assign obs_fault      = sel ? if4.stack_fault : if0.stack_fault;
    assign obs_depth      = sel ? if4.depth       : if0.depth;
    assign obs_state      = sel ? state4          : state0;

    // Per-operation record filled by run_op
    logic [15:0] got_q[$];
    int n_pops, n_pc_load, n_flags_load, n_fault, n_both, busy_cycles, load_cyc, fault_cyc;
    logic [31:0] last_pc;
    logic [2:0]  last_flags;
    logic        done;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offer one request, scramble the operands after acceptance, then watch
    // the outputs each cycle until op_ready returns (bounded).
    task automatic run_op(input logic [1:0] code, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic [2:0] fl);
        got_q.delete();
        n_pops = 0; n_pc_load = 0; n_flags_load = 0; n_fault = 0;
        busy_cycles = 0; load_cyc = 0; fault_cyc = 0;
        last_pc = '0; last_flags = '0; done = 1'b0;
        @(negedge clk);
        op_valid = 1'b1; op_code = code; pc_in = pc; target_in = tgt; flags_in = fl;
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
        pc_in     = $urandom;
        target_in = $urandom;
        flags_in  = 3'($urandom_range(0, 7));
        for (int c = 1; c <= 16 && !done; c++) begin
            @(negedge clk);
            if (obs_push) got_q.push_back(obs_wdata);
            if (obs_pop) n_pops++;
            if (obs_push && obs_pop) n_both++;
            if (obs_busy) busy_cycles++;
            if (obs_pc_load) begin n_pc_load++; last_pc = obs_pc_out; load_cyc = c; end
            if (obs_flags_load) begin n_flags_load++; last_flags = obs_flags_out; end
            if (obs_fault) begin n_fault++; fault_cyc = c; end
            if (obs_ready) done = 1'b1;
        end
        chk("op_ready_returns", 32'(done), 32'd1);
    endtask

    initial begin
        n_both = 0;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_op_ready", 32'(obs_ready), 32'd1);
        chk("rst_busy",     32'(obs_busy), 32'd0);
        chk("rst_push",     32'(obs_push), 32'd0);
        chk("rst_pop",      32'(obs_pop), 32'd0);
        chk("rst_pc_load",  32'(obs_pc_load), 32'd0);
        chk("rst_pc_out",   obs_pc_out, 32'd0);
        chk("rst_fault",    32'(obs_fault), 32'd0);
        chk("rst_depth",    32'(obs_depth), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // CALL
        run_op(2'b00, 32'h0001_2345, 32'h0000_0400, 3'b000);
        chk("call_push_n", got_q.size(), 32'd2);
        chk("call_push0",  32'(got_q[0]), 32'h0001);
        chk("call_push1",  32'(got_q[1]), 32'h2345);
        chk("call_pops",   n_pops, 32'd0);
        chk("call_pc",     last_pc, 32'h0000_0400);
        chk("call_loads",  n_pc_load, 32'd1);
        chk("call_ld_cyc", load_cyc, 32'd3);
        chk("call_busy",   busy_cycles, 32'd3);
        chk("call_depth",  32'(obs_depth), 32'd2);

        // RET
        run_op(2'b01, 32'hFFFF_0000, 32'h1111_1111, 3'b111);
        chk("ret_pops",    n_pops, 32'd2);
        chk("ret_pushes",  got_q.size(), 32'd0);
        chk("ret_pc",      last_pc, 32'h0001_2345);
        chk("ret_ld_cyc",  load_cyc, 32'd4);
        chk("ret_fl_load", n_flags_load, 32'd0);
        chk("ret_busy",    busy_cycles, 32'd4);
        chk("ret_depth",   32'(obs_depth), 32'd0);

        // INT
        run_op(2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 3'b101);
        chk("int_push_n",  got_q.size(), 32'd3);
        chk("int_push0",   32'(got_q[0]), 32'h0005);
        chk("int_push1",   32'(got_q[1]), 32'h0000);
        chk("int_push2",   32'(got_q[2]), 32'h0010);
        chk("int_pc",      last_pc, 32'h0000_0020);
        chk("int_ld_cyc",  load_cyc, 32'd4);
        chk("int_busy",    busy_cycles, 32'd4);
        chk("int_depth",   32'(obs_depth), 32'd3);

        // RTI
        run_op(2'b11, 32'h7777_7777, 32'h8888_8888, 3'b010);
        chk("rti_pops",    n_pops, 32'd3);
        chk("rti_pc",      last_pc, 32'h0000_0010);
        chk("rti_flags",   32'(last_flags), 32'd5);
        chk("rti_fl_load", n_flags_load, 32'd1);
        chk("rti_ld_cyc",  load_cyc, 32'd5);
        chk("rti_busy",    busy_cycles, 32'd5);
        chk("rti_depth",   32'(obs_depth), 32'd0);

        // RET on an empty stack is refused
        run_op(2'b01, 32'h0, 32'h0, 3'b000);
        chk("uflow_fault", n_fault, 32'd1);
        chk("uflow_f_cyc", fault_cyc, 32'd1);
        chk("uflow_pops",  n_pops, 32'd0);
        chk("uflow_loads", n_pc_load, 32'd0);
        chk("uflow_busy",  busy_cycles, 32'd1);
        chk("uflow_depth", 32'(obs_depth), 32'd0);

        // Reset during PUSH_LO of an INT
        @(negedge clk);
        op_valid = 1'b1; op_code = 2'b10; pc_in = 32'h0000_ABCD; target_in = '0; flags_in = 3'b011;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_state",   32'(obs_state), 32'd3);
        chk("mid_wdata",   32'(obs_wdata), 32'h0000_ABCD);
        chk("mid_depth",   32'(obs_depth), 32'd2);
        reset = 1'b0;
        #1;
        chk("mid_rst_push",  32'(obs_push), 32'd0);
        chk("mid_rst_wdata", 32'(obs_wdata), 32'd0);
        chk("mid_rst_depth", 32'(obs_depth), 32'd0);
        chk("mid_rst_ready", 32'(obs_ready), 32'd1);
        chk("mid_rst_state", 32'(obs_state), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_no_load", 32'(obs_pc_load), 32'd0);
        run_op(2'b00, 32'h0003_0004, 32'h0000_0100, 3'b000);
        chk("post_push_n", got_q.size(), 32'd2);
        chk("post_push0",  32'(got_q[0]), 32'h0003);
        chk("post_push1",  32'(got_q[1]), 32'h0004);
        chk("post_pc",     last_pc, 32'h0000_0100);
        chk("post_depth",  32'(obs_depth), 32'd2);

        // Occupancy limits on the STACK_DEPTH=4 instance
        sel = 1'b1;
        @(negedge clk);
        run_op(2'b00, 32'h0005_0006, 32'h0000_0200, 3'b000);
        chk("d4_call1_depth", 32'(obs_depth), 32'd2);
        run_op(2'b10, 32'h0000_0040, 32'h0, 3'b001);
        chk("d4_int_fault",   n_fault, 32'd1);
        chk("d4_int_pushes",  got_q.size(), 32'd0);
        chk("d4_int_loads",   n_pc_load, 32'd0);
        chk("d4_int_depth",   32'(obs_depth), 32'd2);
        run_op(2'b00, 32'h0007_0008, 32'h0000_0300, 3'b000);
        chk("d4_call2_fault", n_fault, 32'd0);
        chk("d4_call2_pc",    last_pc, 32'h0000_0300);
        chk("d4_call2_depth", 32'(obs_depth), 32'd4);
        run_op(2'b00, 32'h0009_000A, 32'h0000_0500, 3'b000);
        chk("d4_call3_fault", n_fault, 32'd1);
        chk("d4_call3_push",  got_q.size(), 32'd0);
        chk("d4_call3_depth", 32'(obs_depth), 32'd4);

        chk("push_pop_overlap", n_both, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
